// File: rtl/branch_predict_unit.sv
// IF-stage BTB lookup with 2-bit saturating counters, EX-stage mispredict detection,
// one-cycle recovery FSM and saturating branch/mispredict statistics.
module branch_predict_unit #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 3,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  output logic              hit,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_hit,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  typedef enum logic {S_IDLE, S_RECOVER} state_t;
  state_t r_state, w_state_nxt;

  logic [ENTRIES-1:0]            r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
  logic [ENTRIES-1:0][PC_W-1:0]  r_target;
  logic [ENTRIES-1:0][1:0]       r_ctr;
  logic [STAT_W-1:0]             r_branch_cnt, r_mispred_cnt;

  logic [IDX_W-1:0] w_if_idx, w_ex_idx;
  logic [TAG_W-1:0] w_if_tag, w_ex_tag;
  logic             w_ex_match, w_upd, w_unused;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[PC_W-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign w_unused = &{1'b0, if_pc[1:0], ex_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is invisible here.
  assign hit = if_valid & (r_state == S_IDLE) & r_valid[w_if_idx] &
               (r_tag[w_if_idx] == w_if_tag) & r_ctr[w_if_idx][1];
  assign pred_target = hit ? r_target[w_if_idx] : '0;

  assign w_ex_match = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
  assign w_upd      = ex_valid & ~stall;

  always_comb begin
    flush       = 1'b0;
    redirect_pc = '0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        if (ex_taken && (!ex_pred_hit || (ex_pred_target != ex_target))) begin
          flush       = 1'b1;
          redirect_pc = ex_target;
        end else if (!ex_taken && ex_pred_hit) begin
          flush       = 1'b1;
          redirect_pc = ex_pc + PC_W'(4);
        end
      end else if (ex_pred_hit) begin
        flush       = 1'b1;
        redirect_pc = ex_pc + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= {ENTRIES{2'b01}};
    end else if (w_upd) begin
      if (ex_is_branch) begin
        if (w_ex_match) begin
          if (ex_taken) begin
            if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            r_target[w_ex_idx] <= ex_target;
          end else if (r_ctr[w_ex_idx] != 2'b00) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= ex_target;
          r_ctr[w_ex_idx]    <= 2'b10;
        end
      end else if (ex_pred_hit && w_ex_match) begin
        r_valid[w_ex_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (!stall) begin
      if (ex_valid && ex_is_branch && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (flush && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A flush seen while recovering still returns to IDLE; recovery is one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (flush && !stall) w_state_nxt = S_RECOVER;
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized and directed bench for branch_predict_unit against a table-level model.
module tb_branch_predict_unit;
  localparam int PC_W = 32, IDX_W = 3, STAT_W = 16, N = 8;
  localparam int SMAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic              if_valid = 1'b0;
  logic [PC_W-1:0]   if_pc = '0;
  logic              hit;
  logic [PC_W-1:0]   pred_target;
  logic              ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_hit = 1'b0;
  logic [PC_W-1:0]   ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic              flush;
  logic [PC_W-1:0]   redirect_pc;
  logic [STAT_W-1:0] branch_cnt, mispred_cnt;

  branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .hit(hit), .pred_target(pred_target), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_hit(ex_pred_hit),
    .ex_pred_target(ex_pred_target), .flush(flush), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: a plain table of entries plus a "recovering" flag.
  bit          m_v[N];
  logic [31:0] m_tag[N], m_tgt[N];
  int          m_ctr[N];
  bit          m_rec;
  int          m_bc, m_mc;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction
  function automatic logic [31:0] tg(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction
  function automatic bit m_lookup(input logic [31:0] pc);
    return m_v[ix(pc)] && (m_tag[ix(pc)] == tg(pc)) && (m_ctr[ix(pc)] >= 2);
  endfunction
  function automatic bit m_hit();
    return if_valid && !m_rec && m_lookup(if_pc);
  endfunction
  function automatic logic [31:0] m_ptgt();
    return m_hit() ? m_tgt[ix(if_pc)] : 32'h0;
  endfunction
  function automatic bit m_flush();
    if (!ex_valid) return 1'b0;
    if (!ex_is_branch) return ex_pred_hit;
    if (ex_taken) return !ex_pred_hit || (ex_pred_target != ex_target);
    return ex_pred_hit;
  endfunction
  function automatic logic [31:0] m_redir();
    if (!m_flush()) return 32'h0;
    return (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_rec = 0; m_bc = 0; m_mc = 0;
  endtask

  // Advance one clock: model follows the inputs held across the rising edge.
  task automatic tick();
    bit fl, mt;
    int i;
    @(posedge clk);
    fl = m_flush();
    if (!stall) begin
      if (ex_valid) begin
        i  = ix(ex_pc);
        mt = m_v[i] && (m_tag[i] == tg(ex_pc));
        if (ex_is_branch) begin
          if (m_bc < SMAX) m_bc++;
          if (mt) begin
            if (ex_taken) begin
              m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
              m_tgt[i] = ex_target;
            end else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end else if (ex_taken) begin
            m_v[i] = 1; m_tag[i] = tg(ex_pc); m_tgt[i] = ex_target; m_ctr[i] = 2;
          end
        end else if (ex_pred_hit && mt) m_v[i] = 0;
      end
      if (fl && m_mc < SMAX) m_mc++;
    end
    m_rec = m_rec ? 1'b0 : (fl && !stall);
    @(negedge clk);
  endtask

  task automatic set_ex(input bit v, input bit br, input bit tk, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit ph, input logic [31:0] pt);
    ex_valid = v; ex_is_branch = br; ex_taken = tk; ex_pc = pc;
    ex_target = tgt; ex_pred_hit = ph; ex_pred_target = pt;
  endtask

  task automatic test_reset();
    rst_n = 0; m_reset();
    if_valid = 1; if_pc = 32'h100;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", hit); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_ptgt got %h exp 0", pred_target); end
    checks++; if (flush !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_flush got %b/%h exp 0/0", flush, redirect_pc); end
    checks++; if (branch_cnt !== '0 || mispred_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_allocate();
    if_valid = 1; if_pc = 32'h100; set_ex(1, 1, 1, 32'h100, 32'h200, 0, 0); #1;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL alloc_flush got %b/%h exp 1/200", flush, redirect_pc); end
    tick(); set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL recover_hit got %b exp 0", hit); end
    tick(); #1;
    checks++; if (hit !== 1'b1 || pred_target !== 32'h200) begin errors++; $display("FAIL alloc_hit got %b/%h exp 1/200", hit, pred_target); end
  endtask

  task automatic test_not_taken();
    set_ex(1, 1, 0, 32'h100, 32'h200, 1, 32'h200); #1;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h104) begin errors++; $display("FAIL nt_flush got %b/%h exp 1/104", flush, redirect_pc); end
    tick(); set_ex(0, 0, 0, 0, 0, 0, 0); tick(); #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nt_hit got %b exp 0", hit); end
  endtask

  task automatic test_target_change();
    set_ex(1, 1, 1, 32'h100, 32'h300, 1, 32'h200); #1;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h300) begin errors++; $display("FAIL tchg_flush got %b/%h exp 1/300", flush, redirect_pc); end
    tick(); set_ex(0, 0, 0, 0, 0, 0, 0); tick(); #1;
    checks++; if (hit !== 1'b1 || pred_target !== 32'h300) begin errors++; $display("FAIL tchg_hit got %b/%h exp 1/300", hit, pred_target); end
  endtask

  task automatic test_alias();
    if_pc = 32'h120; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL alias_tagmiss got %b exp 0", hit); end
    if_pc = 32'h100; set_ex(1, 0, 0, 32'h100, 0, 1, 32'h300); #1;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h104) begin errors++; $display("FAIL alias_flush got %b/%h exp 1/104", flush, redirect_pc); end
    tick(); set_ex(0, 0, 0, 0, 0, 0, 0); tick(); #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL alias_inval got %b exp 0", hit); end
  endtask

  task automatic test_stall();
    int bc, mc;
    set_ex(1, 1, 1, 32'h100, 32'h200, 0, 0); tick();
    set_ex(0, 0, 0, 0, 0, 0, 0); tick();
    bc = m_bc; mc = m_mc;
    stall = 1; if_pc = 32'h100; set_ex(1, 1, 0, 32'h100, 0, 1, 32'h200); #1;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h104) begin errors++; $display("FAIL stall_flush got %b/%h exp 1/104", flush, redirect_pc); end
    tick(); set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (branch_cnt !== STAT_W'(bc) || mispred_cnt !== STAT_W'(mc)) begin errors++; $display("FAIL stall_cnt got %0d/%0d exp %0d/%0d", branch_cnt, mispred_cnt, bc, mc); end
    checks++; if (hit !== 1'b1 || pred_target !== 32'h200) begin errors++; $display("FAIL stall_tbl got %b/%h exp 1/200", hit, pred_target); end
    stall = 0;
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 3000; n++) begin
      stall    = ($urandom_range(0, 7) == 0);
      if_valid = $urandom_range(0, 3) != 0;
      if_pc    = 32'h100 | ($urandom_range(0, 31) << 2);
      pc       = 32'h100 | ($urandom_range(0, 31) << 2);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, pc,
             32'h1000 + ($urandom_range(0, 3) << 2),
             ($urandom_range(0, 3) == 0) ? bit'($urandom_range(0, 1)) : m_lookup(pc),
             ($urandom_range(0, 3) == 0) ? 32'h1000 + ($urandom_range(0, 3) << 2) : m_tgt[ix(pc)]);
      #1;
      checks++;
      if (hit !== m_hit() || pred_target !== m_ptgt() || flush !== m_flush() || redirect_pc !== m_redir() ||
          branch_cnt !== STAT_W'(m_bc) || mispred_cnt !== STAT_W'(m_mc)) begin
        errors++;
        $display("FAIL rand[%0d] got hit=%b pt=%h fl=%b rd=%h bc=%0d mc=%0d exp hit=%b pt=%h fl=%b rd=%h bc=%0d mc=%0d",
                 n, hit, pred_target, flush, redirect_pc, branch_cnt, mispred_cnt,
                 m_hit(), m_ptgt(), m_flush(), m_redir(), m_bc, m_mc);
      end
      tick();
    end
    stall = 0; set_ex(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    int mc;
    tick();
    mc = m_mc;
    set_ex(1, 1, 0, 32'h7000, 0, 0, 0);
    for (int n = 0; n < 70000; n++) tick();
    set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (branch_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_branch got %h exp ffff", branch_cnt); end
    checks++; if (mispred_cnt !== STAT_W'(mc)) begin errors++; $display("FAIL sat_mispred got %0d exp %0d", mispred_cnt, mc); end
  endtask

  task automatic test_reset_mid();
    if_valid = 1; if_pc = 32'h100;
    set_ex(1, 1, 1, 32'h100, 32'h200, 0, 0); tick();
    set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    rst_n = 0; m_reset(); #1;
    checks++; if (hit !== 1'b0 || branch_cnt !== '0 || mispred_cnt !== '0) begin errors++; $display("FAIL rstmid got hit=%b bc=%0d mc=%0d exp 0/0/0", hit, branch_cnt, mispred_cnt); end
    @(negedge clk); rst_n = 1; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rstmid_tbl got %b exp 0", hit); end
    set_ex(1, 1, 1, 32'h100, 32'h200, 0, 0); tick();
    set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (hit !== 1'b0 || mispred_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_fsm got hit=%b mc=%0d exp 0/1", hit, mispred_cnt); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_not_taken();
    test_target_change();
    test_alias();
    test_stall();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
